// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared constants and types for the instruction-fetch stage: the NOP word
// shown to decode when nothing is valid, the PC step, the 2-bit fetch FSM
// state encoding and the {pc, instr} entry layout held in the fetch buffer.
// Lives alongside the OPCODE_* defines used by the control unit.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  // addi x0,x0,0 -- harmless filler for the control unit
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Word-sized PC step
  localparam logic [31:0] PC_INCR = 32'd4;

  // BOOT burns the first clock after reset, RUN is normal streaming, FLUSH is
  // draining stale responses after a redirect, HALT is the sticky
  // misaligned-redirect trap (only reachable with ALIGN_CHECK_EN)
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // One fetch-buffer entry, PC in the upper half
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's bus signals: the instruction-memory request and
// response channel, the redirect input from branch resolution, and the
// valid/ready channel to decode.
//   master : the fetch unit itself
//   slave  : the surrounding memory / decode / branch logic
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, fetch_fault,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, fetch_fault,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small registered FIFO holding fetched {pc, instr} entries.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   push     : write wdata this cycle (ignored when full)
//   pop      : retire the head this cycle (ignored when empty)
//   clear    : synchronous flush, wins over push and pop
//   rdata    : current head entry (only meaningful when count != 0)
//   count    : number of valid entries
// DEPTH must be a power of two so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && (count != FULL);
  assign pop_en  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage itself needs no reset: count gates whether the head is looked at
  always_ff @(posedge clk) begin
    if (push_en && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; a flush simply rewinds everything to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch stage feeding the control unit. Keeps the fetch PC,
// issues in-order word reads to instruction memory, buffers the returned
// words and hands {instr, instr_pc} to decode over valid/ready. A redirect
// flushes the buffer and throws away any responses still in flight.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : instr_fetch_unit_if.master (imem request/response, redirect,
//              decode handshake, fetch_fault)
// Optional build macro ALIGN_CHECK_EN: a redirect to a non-word-aligned
// target traps into HALT with fetch_fault=1 until reset. Without it the low
// two bits of the target are ignored and fetch_fault is tied low.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  fetch_entry_t  head;
  logic          active;
  logic          halted;
  logic          misaligned;
  logic          redirect_take;
  logic          req;
  logic          accept;
  logic          rsp;
  logic          drop_now;
  logic          push;
  logic          pop;
  logic          have_instr;

`ifdef ALIGN_CHECK_EN
  logic fault_q;
  assign misaligned = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_fault = fault_q;
`else
  logic unused_redirect_lsbs;
  assign misaligned = 1'b0;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
  assign bus.fetch_fault = 1'b0;
`endif

  assign active        = (state == ST_RUN) || (state == ST_FLUSH);
  assign halted        = (state == ST_HALT);
  assign redirect_take = bus.redirect_valid && !halted;
  assign target_pc     = {bus.redirect_pc[31:2], 2'b00};

  // A response is only meaningful if something is actually outstanding.
  // It is discarded while draining, in the redirect cycle itself, or in HALT.
  assign rsp      = bus.imem_rvalid && (outstanding != '0);
  assign drop_now = rsp && (bus.redirect_valid || (drop_cnt != '0) || halted);
  assign push     = rsp && !drop_now;

  assign have_instr = (fifo_count != '0);
  assign pop        = have_instr && bus.instr_ready;

  // Issue gate: buffered words plus in-flight reads must stay below the
  // buffer depth. A word leaving to decode this cycle frees its slot for a
  // new read straight away, which is what sustains one instruction per
  // cycle with a 1-cycle memory; the slot is not refilled before next edge.
  assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
  assign req       = active && (occupancy < (CW+1)'(FIFO_DEPTH)) && !bus.redirect_valid;
  assign accept    = req && bus.imem_ready;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = have_instr;
  assign bus.instr       = have_instr ? head.instr : NOP_INSTR;
  assign bus.instr_pc    = have_instr ? head.pc : 32'h0;

  // Number of stale responses still to swallow. A redirect reloads it with
  // whatever will remain in flight once this cycle's response (itself
  // dropped) is accounted for; otherwise each dropped response counts down.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_take) begin
      drop_next = outstanding - CW'(rsp);
    end else if (rsp && (drop_cnt != '0)) begin
      drop_next = drop_cnt - 1'b1;
    end
  end

  // Fetch FSM with its PC and bookkeeping registers. RUN and FLUSH differ
  // only by whether stale responses are pending, so the next state follows
  // drop_next directly. fetch_pc and resp_pc both jump to the target on a
  // redirect so newly returned words get the right PC after the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
`ifdef ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      drop_cnt    <= drop_next;
      if (redirect_take) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_INCR;
        end
        if (push) begin
          resp_pc <= resp_pc + PC_INCR;
        end
      end
      case (state)
        ST_BOOT:           state <= ST_RUN;
        ST_RUN, ST_FLUSH:  state <= (drop_next != '0) ? ST_FLUSH : ST_RUN;
        default:           state <= ST_HALT;
      endcase
`ifdef ALIGN_CHECK_EN
      if (misaligned) begin
        state   <= ST_HALT;
        fault_q <= 1'b1;
      end
`endif
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_take),
    .wdata ({resp_pc, bus.imem_rdata}),
    .rdata (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit (FIFO_DEPTH=2). A behavioural
// memory returns addr ^ 32'hA5A5_0000 with a configurable latency, and a
// stream model predicts the PC sequence decode and memory should see:
// sequential words from the last redirect target. Honours ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk;
  logic rst;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          testCount = 0;
  int          failCount = 0;
  int          cycle = 0;
  int          latMin = 1;
  int          latMax = 1;
  int          acceptedSince = 0;
  int          poppedSince = 0;
  bit          halted = 0;
  bit          justRedirected = 0;
  bit          wrapArmed = 0;
  bit          wrapSeen = 0;
  logic [31:0] expPc = 32'h0;
  logic [31:0] expReqAddr = 32'h0;
  pend_t       pending[$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One full clock cycle: memory response, input drive, checks against the
  // stream model, model update, then advance to the next falling edge
  task automatic applyStimulus(input logic ready, input logic iready,
                               input logic redir, input logic [31:0] rpc);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pending.size() > 0 && pending[0].due <= cycle) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memWord(pending[0].addr);
    end
    bus.imem_ready     = ready;
    bus.instr_ready    = iready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    if (halted) begin
      checkOutput("halt_fault", {31'b0, bus.fetch_fault}, 32'd1);
      checkOutput("halt_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("halt_valid", {31'b0, bus.instr_valid}, 32'd0);
    end else begin
      checkOutput("fault_low", {31'b0, bus.fetch_fault}, 32'd0);
      if (justRedirected) begin
        checkOutput("flushed_after_redirect", {31'b0, bus.instr_valid}, 32'd0);
      end
      if (redir) begin
        checkOutput("req_gated_by_redirect", {31'b0, bus.imem_req}, 32'd0);
      end
      if (bus.instr_valid && iready) begin
        checkOutput("instr_pc", bus.instr_pc, expPc);
        checkOutput("instr", bus.instr, memWord(expPc));
        expPc = expPc + 32'd4;
        poppedSince++;
      end else if (!bus.instr_valid) begin
        checkOutput("nop_when_empty", bus.instr, NOP);
      end
      if (bus.imem_req) begin
        checkOutput("imem_addr", bus.imem_addr, expReqAddr);
        if (ready) begin
          pending.push_back('{addr: bus.imem_addr,
                              due: cycle + $urandom_range(latMax, latMin)});
          if (wrapArmed && bus.imem_addr == 32'h0) wrapSeen = 1;
          expReqAddr = expReqAddr + 32'd4;
          acceptedSince++;
        end
      end
      checkOutput("inflight_bound",
                  (acceptedSince - poppedSince <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    end
    justRedirected = 0;
    if (redir && !halted) begin
`ifdef ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) halted = 1;
`endif
      if (!halted) begin
        expPc          = {rpc[31:2], 2'b00};
        expReqAddr     = {rpc[31:2], 2'b00};
        acceptedSince  = 0;
        poppedSince    = 0;
        justRedirected = 1;
      end
    end
    if (bus.imem_rvalid) void'(pending.pop_front());
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  logic [31:0] heldInstr;
  logic [31:0] heldPc;
  logic [31:0] rpc;
  bit          found;

  initial begin
    // Reset state
    rst                = 1'b1;
    bus.imem_ready     = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
    #2;
    checkOutput("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    checkOutput("rst_instr", bus.instr, NOP);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("rst_fetch_fault", {31'b0, bus.fetch_fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // BOOT cycle issues nothing; the first read goes out the cycle after
    #1;
    checkOutput("boot_no_req", {31'b0, bus.imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("first_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("first_addr", bus.imem_addr, 32'h0);

    // Streaming, 1-cycle memory: one instruction per cycle once primed
    for (int i = 0; i < 30; i++) begin
      if (i >= 2) checkOutput("throughput", {31'b0, bus.instr_valid}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Decode stalls for 10 cycles: outputs frozen, issue stops
    heldInstr = bus.instr;
    heldPc    = bus.instr_pc;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
      checkOutput("stall_instr", bus.instr, heldInstr);
      checkOutput("stall_pc", bus.instr_pc, heldPc);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("stall_req_low", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two reads outstanding: both must be swallowed
    latMin = 4;
    latMax = 4;
    found  = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pending.size() == 2 && pending[0].due > cycle) found = 1;
      else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("two_outstanding_found", {31'b0, found}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_progress", (poppedSince > 0) ? 32'd1 : 32'd0, 32'd1);

    // Redirect coinciding with a response and a decode handshake
    latMin = 1;
    latMax = 1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.instr_valid && pending.size() > 0 && pending[0].due <= cycle) found = 1;
      else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("collision_found", {31'b0, found}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap from the top of the address space
    wrapArmed = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("pc_wrap", {31'b0, wrapSeen}, 32'd1);
    wrapArmed = 0;

    // Misaligned redirect target
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifndef ALIGN_CHECK_EN
    checkOutput("misaligned_ignored", (poppedSince > 0) ? 32'd1 : 32'd0, 32'd1);
`endif

    // Reset in the middle of traffic clears everything immediately
    rst = 1'b1;
    #1;
    checkOutput("midrst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    checkOutput("midrst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("midrst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    checkOutput("midrst_fetch_fault", {31'b0, bus.fetch_fault}, 32'd0);
    pending.delete();
    halted         = 0;
    justRedirected = 0;
    expPc          = 32'h0;
    expReqAddr     = 32'h0;
    acceptedSince  = 0;
    poppedSince    = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic: stalls on both sides, variable latency, redirects
    latMin = 1;
    latMax = 3;
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom;
`ifdef ALIGN_CHECK_EN
      rpc[1:0] = 2'b00;
`endif
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
                    $urandom_range(99, 0) < 3, rpc);
    end
    checkOutput("random_progress", (poppedSince > 0 || justRedirected) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small FIFO and presents {instruction, PC} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, 2..8.
- NOP_INSTR, 32'h0000_0013, value driven on instr when the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  redirect request from branch/JAL/JALR resolution.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts this cycle.
- instr  out  32  instruction word to the control unit.
- instr_pc  out  32  PC of instr.
- fetch_fault  out  1  misaligned redirect detected (ALIGN_CHECK_EN only, else tied 0).

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP_INSTR, instr_pc=0, fetch_fault=0.
- FSM states: BOOT, RUN, FLUSH, HALT (HALT only with ALIGN_CHECK_EN).
  - BOOT->RUN unconditionally after the first clock with rst=0. No request is issued in BOOT.
  - RUN->FLUSH on redirect_valid when in-flight requests remain after this cycle's response.
  - FLUSH->RUN when drop_cnt reaches 0.
  - A redirect in FLUSH reloads drop_cnt.
- Request issue:
  - imem_req=1 when the state is RUN or FLUSH, (fifo_count + outstanding) < FIFO_DEPTH, and redirect_valid=0. imem_req is combinationally gated low by redirect_valid.
  - imem_addr=fetch_pc.
  - On imem_req & imem_ready: fetch_pc += 4 (modulo 2^32, wraps to 0) and outstanding++.
- Response:
  - On imem_rvalid: outstanding--.
  - If drop_cnt>0: the word is discarded and drop_cnt--.
  - Otherwise push {imem_rdata, pc_of_response} into the FIFO. The response PC is tracked by a second counter, resp_pc, that advances by 4 per accepted response.
  - The FIFO never overflows, by construction of the issue rule.
- Output:
  - instr_valid = FIFO non-empty; instr/instr_pc come from the FIFO head.
  - When empty, instr=NOP_INSTR.
  - Pop on instr_valid & instr_ready.
  - Fall-through latency: a response at cycle N is visible at the output in cycle N+1 (registered FIFO).
- Redirect (redirect_valid=1):
  - FIFO cleared at the clock edge.
  - fetch_pc and resp_pc load {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (imem_rvalid ? 1 : 0).
  - An output handshake in the same cycle still completes. Squashing that word is the redirect source's responsibility.
  - A response arriving in the redirect cycle is dropped.
- Throughput: one instruction per cycle sustained when imem_ready=1 and latency ≤ FIFO_DEPTH−1 cycles.
- Back-pressure: instr_ready=0 holds the outputs stable. Issue stops once the FIFO plus in-flight requests reach FIFO_DEPTH.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset requests are not expected; memory is reset together with this block.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 enters HALT, drives fetch_fault=1 and clears the FIFO.
  - imem_req stays 0 and late responses are dropped.
  - HALT is left only by reset.
- Undefined: redirect_pc[1:0] is ignored (forced to 0), fetch_fault is tied 0 and HALT does not exist.

Decomposition:
- Shared package/defines header (alongside the existing OPCODE_* defines):
  - NOP_INSTR constant.
  - Fetch FSM state encodings (2-bit).
  - PC increment constant 4.
- Natural sub-module: fetch_fifo.
  - Parameterised depth and width (64-bit {pc, instr}).
  - Synchronous push/pop/clear, async active-high reset.
  - Count output.

Test Plan:
- Reset then run with imem_ready=1, 1-cycle latency, rdata=addr^32'hA5A5_0000, instr_ready=1 -> first request at addr 0 in cycle 2. instr_pc sequence 0,4,8,... one per cycle, instr matching the data.
- instr_ready=0 for 10 cycles -> outputs held stable, at most 2 requests in flight/buffered, imem_req drops to 0. Release -> order preserved, no loss or duplication.
- Redirect to 32'h100 while 2 requests are outstanding -> both responses dropped, next instr_pc=32'h100, FIFO cleared.
- Redirect in the same cycle as imem_rvalid and an output handshake -> response dropped, imem_req=0 that cycle, next fetch at the target.
- fetch_pc=32'hFFFF_FFFC -> next request address 32'h0000_0000 (wrap).
- ALIGN_CHECK_EN: redirect_pc=32'h102 -> fetch_fault=1, no further imem_req, instr_valid=0 until rst.
